// File: rtl/lii_pkg.sv
// Shared LII definitions: packet header field widths and the scheduler state encoding.
package lii_pkg;

  localparam int TYPE_W = 2;
  localparam int DST_W  = 3;
  localparam int SRC_W  = 3;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/lii_rr_pick.sv
// Combinational round-robin picker: first set request at or after i_ptr, wrapping.
module lii_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_onehot,
  output logic          o_valid
);

  logic          w_found;
  logic [PW:0]   w_sum;
  logic [PW-1:0] w_idx;

  always_comb begin
    o_onehot = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, i_ptr} + (PW+1)'(k);
      if (w_sum >= (PW+1)'(N)) w_sum = w_sum - (PW+1)'(N);
      w_idx = w_sum[PW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_onehot[w_idx] = 1'b1;
        w_found         = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/lii_pkt_sched.sv
// Per-output wormhole scheduler: two-class round-robin with low-class aging and credit flow control.
module lii_pkt_sched
  import lii_pkg::*;
#(
  parameter int N_IN         = 4,
  parameter int TYPE_W       = lii_pkg::TYPE_W,
  parameter int TYPE_PRIO    = 2,
  parameter int CREDIT_W     = 4,
  parameter int CREDITS_INIT = 8,
  parameter int AGE_MAX      = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          req,
  input  logic [N_IN-1:0]          req_last,
  input  logic [N_IN*TYPE_W-1:0]   req_type,
  input  logic                     out_ready,
  input  logic                     credit_ret,
  output logic [N_IN-1:0]          gnt,
  output logic                     gnt_v,
  output logic                     locked,
  output logic [CREDIT_W-1:0]      credit_cnt,
  output logic                     credit_err
);

  localparam int PW     = $clog2(N_IN);
  localparam int AGE_W  = $clog2(AGE_MAX + 1);
  localparam int MASK_W = 1 << TYPE_W;
  localparam logic [MASK_W-1:0]   PRIO_MASK = MASK_W'(TYPE_PRIO);
  localparam logic [CREDIT_W-1:0] CRED_MAX  = CREDIT_W'(CREDITS_INIT);
  localparam logic [AGE_W-1:0]    AGE_TOP   = AGE_W'(AGE_MAX);

  sched_state_t        r_state, w_state_nxt;
  logic [PW-1:0]       r_hi_ptr, r_lo_ptr, r_owner;
  logic                r_owner_lo;
  logic [CREDIT_W-1:0] r_credit;
  logic                r_credit_err;
  logic [AGE_W-1:0]    r_age;

  logic [N_IN-1:0] w_hi_mask, w_hi_req, w_lo_req, w_hi_gnt, w_lo_gnt, w_pick;
  logic            w_hi_v, w_lo_v, w_promote, w_pick_lo, w_has_credit;
  logic            w_acc, w_win_last, w_cls_lo, w_acc_lo;
  logic [PW-1:0]   w_win_idx, w_nxt_ptr;

  always_comb begin
    w_hi_mask = '0;
    for (int i = 0; i < N_IN; i++) w_hi_mask[i] = PRIO_MASK[req_type[i*TYPE_W +: TYPE_W]];
  end

  assign w_hi_req = req & w_hi_mask;
  assign w_lo_req = req & ~w_hi_mask;

  lii_rr_pick #(.N(N_IN), .PW(PW)) u_pick_hi (
    .i_req(w_hi_req), .i_ptr(r_hi_ptr), .o_onehot(w_hi_gnt), .o_valid(w_hi_v)
  );

  lii_rr_pick #(.N(N_IN), .PW(PW)) u_pick_lo (
    .i_req(w_lo_req), .i_ptr(r_lo_ptr), .o_onehot(w_lo_gnt), .o_valid(w_lo_v)
  );

  // A saturated age counter lets a pending low request jump ahead of the high class once.
  assign w_promote    = (r_age == AGE_TOP) && w_lo_v;
  assign w_pick_lo    = w_lo_v && (!w_hi_v || w_promote);
  assign w_pick       = w_pick_lo ? w_lo_gnt : w_hi_gnt;
  assign w_has_credit = (r_credit != '0);

  // Handshake: a beat transfers in the cycle where gnt_v and out_ready are both high.
  always_comb begin
    gnt = '0;
    if (w_has_credit) begin
      if (r_state == IDLE)     gnt = w_pick;
      else if (req[r_owner])   gnt = N_IN'(1) << r_owner;
    end
  end

  assign gnt_v  = |gnt;
  assign locked = (r_state == LOCK);
  assign w_acc  = gnt_v & out_ready;

  always_comb begin
    w_win_idx = '0;
    for (int i = 0; i < N_IN; i++) if (gnt[i]) w_win_idx = PW'(i);
  end

  assign w_win_last = |(gnt & req_last);
  assign w_cls_lo   = (r_state == IDLE) ? w_pick_lo : r_owner_lo;
  assign w_acc_lo   = w_acc & w_cls_lo;
  assign w_nxt_ptr  = (w_win_idx == PW'(N_IN - 1)) ? '0 : w_win_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_acc && !w_win_last) w_state_nxt = LOCK;
      LOCK: if (w_acc && w_win_last)  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi_ptr     <= '0;
      r_lo_ptr     <= '0;
      r_owner      <= '0;
      r_owner_lo   <= 1'b0;
      r_credit     <= CRED_MAX;
      r_credit_err <= 1'b0;
      r_age        <= '0;
    end else begin
      if (r_state == IDLE && w_acc && !w_win_last) begin
        r_owner    <= w_win_idx;
        r_owner_lo <= w_pick_lo;
      end
      if (w_acc && w_win_last) begin
        if (w_cls_lo) r_lo_ptr <= w_nxt_ptr;
        else          r_hi_ptr <= w_nxt_ptr;
      end
      if (!w_lo_v || w_acc_lo) r_age <= '0;
      else if (r_age != AGE_TOP) r_age <= r_age + 1'b1;
      case ({w_acc, credit_ret})
        2'b10: r_credit <= r_credit - 1'b1;
        2'b01: begin
          if (r_credit == CRED_MAX) r_credit_err <= 1'b1;
          else                      r_credit     <= r_credit + 1'b1;
        end
        default: r_credit <= r_credit;
      endcase
    end
  end

  assign credit_cnt = r_credit;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_lii_pkt_sched.sv
// Directed bench for lii_pkt_sched: vector tables plus hand-built credit, aging and reset sequences.
module tb_lii_pkt_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req_last;
  logic [7:0] req_type;
  logic       out_ready, credit_ret;
  logic [3:0] gnt;
  logic       gnt_v, locked;
  logic [3:0] credit_cnt;
  logic       credit_err;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  typedef struct {
    logic [3:0] r;
    logic [3:0] l;
    logic [7:0] t;
    logic       rdy;
    logic       cr;
    logic [3:0] eg;
    logic       el;
    logic [3:0] ec;
  } vec_t;

  vec_t t1[3];
  vec_t t2[6];

  lii_pkt_sched dut (
    .clk(clk), .rst(rst), .req(req), .req_last(req_last), .req_type(req_type),
    .out_ready(out_ready), .credit_ret(credit_ret), .gnt(gnt), .gnt_v(gnt_v),
    .locked(locked), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic step(input string name, input logic [3:0] r, input logic [3:0] l,
                      input logic [7:0] t, input logic rdy, input logic cr,
                      input logic [3:0] eg, input logic el, input logic [3:0] ec,
                      input logic ee);
    logic [10:0] act, exp;
    @(negedge clk);
    rst = 1'b0; req = r; req_last = l; req_type = t; out_ready = rdy; credit_ret = cr;
    exp_q.push_back({eg, |eg, el, ec, ee});
    #3;
    act = {gnt, gnt_v, locked, credit_cnt, credit_err};
    exp = exp_q.pop_front();
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got gnt=%b v=%b locked=%b cnt=%0d err=%b, want gnt=%b v=%b locked=%b cnt=%0d err=%b",
               name, act[10:7], act[6], act[5], act[4:1], act[0],
               exp[10:7], exp[6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; req_last = '0; req_type = '0; out_ready = 1'b1; credit_ret = 1'b0;
    step("reset_state", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd8, 1'b0);
  endtask

  initial begin
    t1[0] = '{4'b0101, 4'b0101, 8'h55, 1'b1, 1'b1, 4'b0001, 1'b0, 4'd8};
    t1[1] = '{4'b0101, 4'b0101, 8'h55, 1'b1, 1'b1, 4'b0100, 1'b0, 4'd8};
    t1[2] = '{4'b0101, 4'b0101, 8'h55, 1'b1, 1'b1, 4'b0001, 1'b0, 4'd8};

    t2[0] = '{4'b0001, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd8};
    t2[1] = '{4'b0011, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0001, 1'b1, 4'd7};
    t2[2] = '{4'b0011, 4'b0000, 8'h55, 1'b0, 1'b0, 4'b0001, 1'b1, 4'd6};
    t2[3] = '{4'b0010, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0000, 1'b1, 4'd6};
    t2[4] = '{4'b0011, 4'b0001, 8'h55, 1'b1, 1'b0, 4'b0001, 1'b1, 4'd6};
    t2[5] = '{4'b0011, 4'b0011, 8'h55, 1'b1, 1'b0, 4'b0010, 1'b0, 4'd5};

    rst = 1'b1; req = '0; req_last = '0; req_type = '0; out_ready = 1'b0; credit_ret = 1'b0;

    do_reset();
    foreach (t1[i])
      step($sformatf("hi_rr[%0d]", i), t1[i].r, t1[i].l, t1[i].t, t1[i].rdy, t1[i].cr,
           t1[i].eg, t1[i].el, t1[i].ec, 1'b0);

    do_reset();
    foreach (t2[i])
      step($sformatf("wormhole[%0d]", i), t2[i].r, t2[i].l, t2[i].t, t2[i].rdy, t2[i].cr,
           t2[i].eg, t2[i].el, t2[i].ec, 1'b0);

    // Credit drain: eight beats, stall at zero, one returned credit buys one more beat.
    do_reset();
    for (int c = 0; c < 8; c++)
      step($sformatf("drain[%0d]", c), 4'b0100, 4'b0100, 8'h55, 1'b1, 1'b0,
           4'b0100, 1'b0, 4'(8 - c), 1'b0);
    step("drain_empty0", 4'b0100, 4'b0100, 8'h55, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    step("drain_empty1", 4'b0100, 4'b0100, 8'h55, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);
    step("drain_ret",    4'b0100, 4'b0100, 8'h55, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd0, 1'b0);
    step("drain_one",    4'b0100, 4'b0100, 8'h55, 1'b1, 1'b0, 4'b0100, 1'b0, 4'd1, 1'b0);
    step("drain_again",  4'b0100, 4'b0100, 8'h55, 1'b1, 1'b0, 4'b0000, 1'b0, 4'd0, 1'b0);

    // Aging: req0 high (type 1), req3 low (type 0); req3 wins on its 16th waiting cycle.
    do_reset();
    for (int c = 1; c <= 18; c++)
      step($sformatf("age[%0d]", c), 4'b1001, 4'b1001, 8'h01, 1'b1, 1'b1,
           (c == 16) ? 4'b1000 : 4'b0001, 1'b0, 4'd8, 1'b0);

    // Credit overflow is sticky until reset.
    do_reset();
    step("err_pulse", 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b1, 4'b0000, 1'b0, 4'd8, 1'b0);
    for (int c = 0; c < 3; c++)
      step($sformatf("err_sticky[%0d]", c), 4'b0000, 4'b0000, 8'h00, 1'b1, 1'b0,
           4'b0000, 1'b0, 4'd8, 1'b1);

    // Reset mid-packet with owner 2 after the high pointer had moved to 1.
    do_reset();
    step("pre_single",  4'b0001, 4'b0001, 8'h55, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd8, 1'b0);
    step("pre_head",    4'b0100, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0100, 1'b0, 4'd7, 1'b0);
    step("pre_body",    4'b0100, 4'b0000, 8'h55, 1'b1, 1'b0, 4'b0100, 1'b1, 4'd6, 1'b0);
    do_reset();
    step("post_rst_ptr0", 4'b0101, 4'b0101, 8'h55, 1'b1, 1'b0, 4'b0001, 1'b0, 4'd8, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lii_pkt_sched.md
Name: lii_pkt_sched

Overview:
- Per-output packet scheduler for the LII crossbar.
- Arbitrates N_IN requesters onto one output lane with wormhole locking: an owner holds the lane from first beat to last beat.
- Two priority classes, per-class round-robin, starvation promotion of the low class, and downstream credit-based flow control (one credit per beat).
- One instance sits in front of each crossbar output's one-hot mux and drives its select vector.

Parameters:
- N_IN, 4, number of requesters (≥2).
- TYPE_W, 2, width of each requester's type field.
- TYPE_PRIO, 2, bitmask over type values; bit t set means type t is high class.
- CREDIT_W, 4, credit counter width.
- CREDITS_INIT, 8, credits after reset and maximum credit level (≤2^CREDIT_W-1).
- AGE_MAX, 15, low-class starvation threshold in cycles (≥1).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- req  in  N_IN  per-requester valid (head beat present).
- req_last  in  N_IN  per-requester last flag of head beat.
- req_type  in  N_IN*TYPE_W  per-requester type, flattened, requester i at [i*TYPE_W +: TYPE_W].
- out_ready  in  1  downstream accepts current beat.
- credit_ret  in  1  one-cycle pulse, downstream returns one credit.
- gnt  out  N_IN  one-hot grant / mux select, all-zero when none.
- gnt_v  out  1  OR of gnt.
- locked  out  1  packet in flight (LOCK state).
- credit_cnt  out  CREDIT_W  current credits.
- credit_err  out  1  sticky; a return arrived at CREDITS_INIT.

Behaviour:
- Reset (clk edge with rst=1) overrides any in-flight packet:
  - state=IDLE, both RR pointers=0, credit_cnt=CREDITS_INIT, age=0, credit_err=0.
  - Therefore gnt=0, gnt_v=0, locked=0.
- Beat accept: acc = gnt_v & out_ready. The grant is combinational from current state and inputs, so there is zero-cycle latency from req to gnt.
- No grant is issued when credit_cnt==0, in either state.
- Classify requester i as high if TYPE_PRIO bit[req_type_i] is set, else low.
- Arbitration in IDLE:
  - Pick from the high class, round-robin, starting at hi_ptr.
  - Pick from the low class, RR from lo_ptr, if no high request exists, or if age==AGE_MAX and a low request exists (promotion).
- On acc in IDLE:
  - req_last=1 (single-beat packet): stay IDLE; advance the winning class pointer to winner+1 mod N_IN.
  - req_last=0: go to LOCK; register the owner index and owner class.
- LOCK:
  - gnt = onehot(owner) when req[owner] & credit_cnt>0, else 0.
  - Other requests are ignored. The owner dropping req is a bubble; stay LOCK.
  - On acc with req_last[owner]=1: go to IDLE and advance the owner-class pointer to owner+1.
- Age counter:
  - Increments (saturating at AGE_MAX) each cycle a low request is pending and no low-class beat is accepted.
  - Clears on any low-class acc, or when no low request is pending.
  - After a promoted grant, age clears on that acc.
- Credits:
  - next = credit_cnt − acc + credit_ret.
  - If acc and credit_ret occur together, the count is unchanged.
  - credit_ret with credit_cnt==CREDITS_INIT and no acc: count held, credit_err set.
  - Underflow is impossible by construction.
- Type changes on a non-head beat do not affect the lock.

Decomposition:
- Shared package lii_pkg holds the LII field widths (TYPE_W, DST_W, SRC_W) and the scheduler state encoding (IDLE, LOCK).
- One sub-module, lii_rr_pick: combinational N_IN round-robin picker (req, ptr → one-hot, valid), instantiated twice, high and low.
- Pointer registers stay in the parent.

Test Plan:
- Single-beat hi packets on req=4'b0101, out_ready=1, credit_ret tied 1 → gnt alternates 0001, 0100, 0001; credit_cnt stays 8.
- Req0 sends 3-beat packet (last on beat 3), req1 requests from cycle 1 → gnt=0001 for 3 accepted beats, locked=1 during them, then gnt=0010.
- credit_ret=0, continuous req2 single beats → exactly 8 grants; credit_cnt reaches 0 and gnt_v=0; one credit_ret pulse → exactly one further grant.
- Req0 continuous high type 1, req3 low type 0, AGE_MAX=15 → req3 granted on the 16th cycle of waiting, age clears, then high resumes.
- credit_ret pulse at credit_cnt=8 with no accept → credit_cnt stays 8, credit_err=1 and stays 1 until rst.
- rst asserted mid-packet while LOCK, owner=2 → next cycle locked=0, gnt=0, credit_cnt=8; the first grant afterwards follows pointer 0.
